// File: rtl/nios_oe_sequencer.sv
// nios_oe_sequencer
// Applies a requested output-enable mask to the voltage-control front end.
// Bits that go to the safe state (1) are applied together, on the next edge.
// Bits that leave the safe state (1 -> 0) are released one channel at a time,
// lowest index first, with a programmable gap between releases.
// An Avalon-MM slave holds the spacing register and reports status.
// Requires WIDTH <= 32 and DLY_W < 32, so that both zero-extend into readdata.
module nios_oe_sequencer #(
    parameter int WIDTH         = 32,
    parameter int DLY_W         = 16,
    parameter int DEFAULT_DELAY = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] oe_req,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] oe_out,
    output logic             busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   oe_q, oe_d;
    logic [DLY_W-1:0]   cnt_q, cnt_d;
    logic [DLY_W-1:0]   dly_q, dly_d;

    logic [WIDTH-1:0]   set_mask_s;
    logic [WIDTH-1:0]   pend_s;
    logic [WIDTH-1:0]   clr_s;
    logic               reg_wr_s;
    logic [31:0]        rd_dly_s;
    logic [31:0]        rd_oe_s;
    logic               unused_s;

    // Only the low DLY_W bits of writedata reach a register.
    assign unused_s = ^writedata;

    // State register: every flop of the block, asynchronously reset to the safe state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            oe_q    <= {WIDTH{1'b1}};
            cnt_q   <= {DLY_W{1'b0}};
            dly_q   <= DLY_W'(DEFAULT_DELAY);
        end else begin
            state_q <= state_d;
            oe_q    <= oe_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
        end
    end

    // Next-state logic: sequencer FSM, immediate safe-set path and the spacing register.
    always_comb begin
        // set_mask and pend are disjoint by construction, so the safe set and
        // a sequenced release on another bit can share one edge.
        set_mask_s = oe_req & ~oe_q;
        pend_s     = oe_q & ~oe_req;
        clr_s      = {WIDTH{1'b0}};
        state_d    = state_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_s != {WIDTH{1'b0}}) begin
                    // Isolate the lowest-index pending bit.
                    clr_s   = pend_s & (~pend_s + WIDTH'(1));
                    cnt_d   = dly_q;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != {DLY_W{1'b0}}) begin
                    cnt_d = cnt_q - DLY_W'(1);
                end else begin
                    // Exit cycle: no release here, pend is re-evaluated in IDLE.
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        oe_d = (oe_q | set_mask_s) & ~clr_s;

        // A spacing write takes effect at the next counter load only.
        reg_wr_s = chipselect & ~write_n;
        if (reg_wr_s && (address == 2'd0)) begin
            dly_d = writedata[DLY_W-1:0];
        end else begin
            dly_d = dly_q;
        end
    end

    // Output logic: busy flag and zero-wait-state read mux (independent of chipselect).
    always_comb begin
        busy                = (state_q == ST_WAIT) | (pend_s != {WIDTH{1'b0}});
        rd_dly_s            = 32'd0;
        rd_dly_s[DLY_W-1:0] = dly_q;
        rd_oe_s             = 32'd0;
        rd_oe_s[WIDTH-1:0]  = oe_q;
        case (address)
            2'd0:    readdata = rd_dly_s;
            2'd1:    readdata = {30'd0, (state_q == ST_WAIT), busy};
            2'd2:    readdata = rd_oe_s;
            2'd3:    readdata = 32'd0;
            default: readdata = 32'd0;
        endcase
    end

    assign oe_out = oe_q;

endmodule

// File: tb/tb_nios_oe_sequencer.sv
// Directed bench for nios_oe_sequencer: drives on the falling edge, samples
// on the falling edge, expected masks computed from the release schedule.
module tb_nios_oe_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] oe_req;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] oe_out;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    nios_oe_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .oe_req     (oe_req),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .oe_out     (oe_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    // Called just after a falling edge; consumes one rising edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        logic [31:0] exp;
        int          n;
        int          e5 [4];

        reset_n    = 1'b0;
        oe_req     = 32'hFFFF_FFFF;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;

        // ---- reset and release ----
        repeat (3) @(negedge clk);
        chk("rst_oe_in_reset", oe_out, 32'hFFFF_FFFF);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_oe", oe_out, 32'hFFFF_FFFF);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk_rd("rst_delay", 2'd0, 32'd1000);
        chk_rd("rst_status", 2'd1, 32'd0);
        chk_rd("rst_rd_oe", 2'd2, 32'hFFFF_FFFF);
        chk_rd("rst_rd_a3", 2'd3, 32'd0);
        wr(2'd2, 32'd0);
        chk("ro_write_ignored", oe_out, 32'hFFFF_FFFF);
        wr(2'd0, 32'd3);
        chk_rd("delay_3", 2'd0, 32'd3);

        // ---- release bits 0..3, delay 3 -> clears on edges 1,6,11,16 ----
        @(negedge clk);
        oe_req = 32'hFFFF_FFF0;
        #1;
        chk("t2_busy_comb", {31'd0, busy}, 32'd1);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            exp = 32'hFFFF_FFFF;
            for (int i = 0; i < 4; i++) if (c >= 1 + 5 * i) exp[i] = 1'b0;
            chk("t2_oe", oe_out, exp);
            if (c == 19) chk("t2_busy_last_wait", {31'd0, busy}, 32'd1);
            if (c == 20) chk("t2_busy_done", {31'd0, busy}, 32'd0);
        end

        // ---- re-assert everything after bit 1 has cleared ----
        oe_req = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("t3_restore", oe_out, 32'hFFFF_FFFF);
        oe_req = 32'hFFFF_FFF0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c <= 5)       exp = 32'hFFFF_FFFE;
            else if (c == 6)  exp = 32'hFFFF_FFFC;
            else              exp = 32'hFFFF_FFFF;
            chk("t3_oe", oe_out, exp);
            if (c == 6) oe_req = 32'hFFFF_FFFF;
            if (c == 8) chk_rd("t3_status_wait", 2'd1, 32'd3);
            if (c == 9) chk("t3_busy_wait", {31'd0, busy}, 32'd1);
            if (c == 10) chk("t3_busy_idle", {31'd0, busy}, 32'd0);
            if (c == 12) chk_rd("t3_status_idle", 2'd1, 32'd0);
        end

        // ---- delay 0: release bits 4..31 every 2 cycles ----
        wr(2'd0, 32'd0);
        chk_rd("delay_0", 2'd0, 32'd0);
        @(negedge clk);
        oe_req = 32'h0000_000F;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            n = (c + 1) / 2;
            if (n > 28) n = 28;
            exp = 32'hFFFF_FFFF;
            for (int i = 0; i < n; i++) exp[4 + i] = 1'b0;
            chk("t4_oe", oe_out, exp);
            if (c == 55) chk("t4_busy_last", {31'd0, busy}, 32'd1);
            if (c == 56) chk("t4_busy_done", {31'd0, busy}, 32'd0);
        end
        chk("t4_final", oe_out, 32'h0000_000F);

        // ---- delay rewrite while counter = 5 ----
        oe_req = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("t5_restore", oe_out, 32'hFFFF_FFFF);
        wr(2'd0, 32'd7);
        oe_req = 32'hFFFF_FFF0;
        e5 = '{1, 10, 22, 34};
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            exp = 32'hFFFF_FFFF;
            for (int i = 0; i < 4; i++) if (c >= e5[i]) exp[i] = 1'b0;
            chk("t5_oe", oe_out, exp);
            if (c == 3) begin
                address    = 2'd0;
                writedata  = 32'd10;
                chipselect = 1'b1;
                write_n    = 1'b0;
            end
            if (c == 4) begin
                chipselect = 1'b0;
                write_n    = 1'b1;
            end
            if (c == 5) address = 2'd1;
            if (c == 8) chk("t5_status_cnt0", readdata, 32'd3);
            if (c == 9) chk("t5_status_exit", readdata, 32'd1);
        end
        chk_rd("t5_delay_10", 2'd0, 32'd10);

        // ---- asynchronous reset mid-WAIT ----
        oe_req = 32'hFFFF_FFFF;
        repeat (15) @(negedge clk);
        chk("t6_idle_busy", {31'd0, busy}, 32'd0);
        wr(2'd0, 32'd2);
        oe_req = 32'hFFFF_FF00;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            exp = 32'hFFFF_FFFF;
            for (int i = 0; i < 8; i++) if (c >= 1 + 4 * i) exp[i] = 1'b0;
            chk("t6_oe", oe_out, exp);
        end
        chk("t6_busy_pre", {31'd0, busy}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_oe", oe_out, 32'hFFFF_FFFF);
        address = 2'd0;
        #0.5;
        chk("t6_rst_delay", readdata, 32'd1000);
        oe_req  = 32'hFFFF_FFFF;
        address = 2'd1;
        #0.5;
        chk("t6_rst_status", readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("t6_post_busy", {31'd0, busy}, 32'd0);
            chk("t6_post_oe", oe_out, 32'hFFFF_FFFF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nios_oe_sequencer.md
Name: nios_oe_sequencer

Overview:
- Sits directly downstream of the output-enable PIO register and consumes its 32-bit out_port as the requested OE mask.
- Drives the physical channel-enable lines of the voltage-control front end.
- Bits moving to the safe state (1) apply at once, all together.
- Bits leaving the safe state (1 -> 0) apply one channel at a time, with a programmable spacing, to limit inrush and rail disturbance.
- Carries its own Avalon-MM slave for the spacing setting and for status.

Parameters:
- WIDTH, 32: number of OE channels.
- DLY_W, 16: width of the inter-step delay counter and register.
- DEFAULT_DELAY, 1000: reset value of the delay register, in clk cycles.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- oe_req  input  WIDTH  requested mask; connects to the PIO out_port.
- address  input  2  Avalon-MM word address.
- chipselect  input  1  Avalon-MM select.
- write_n  input  1  Avalon-MM write strobe, active-low.
- writedata  input  32  Avalon-MM write data.
- readdata  output  32  Avalon-MM read data; combinational, zero wait states.
- oe_out  output  WIDTH  applied mask, registered.
- busy  output  1  sequencing in progress.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, reset_n.
- Reset values, applied immediately on reset_n low, including mid-sequence:
  - oe_out = all ones
  - state = IDLE
  - delay_reg = DEFAULT_DELAY
  - counter = 0
  - busy = 0
- No sequencing happens out of reset: reset values of oe_out and the PIO output match.
- Definitions, evaluated every cycle from current oe_req and oe_out:
  - set_mask = oe_req & ~oe_out
  - pend = oe_out & ~oe_req
- Safe path, active in every state: each rising edge, oe_out |= set_mask. Latency is 1 cycle.
- FSM states: IDLE, WAIT.
  - IDLE, pend != 0: clear the lowest-index set bit of pend in oe_out; counter <= delay_reg; go to WAIT.
  - IDLE, pend == 0: stay in IDLE.
  - WAIT, counter != 0: decrement counter.
  - WAIT, counter == 0: go to IDLE. No clear happens on this edge.
- Timing: first clear lands 1 edge after pend becomes nonzero in IDLE. Successive clears are exactly delay_reg+2 cycles apart. delay_reg = 0 gives 2-cycle spacing.
- pend is recomputed in every IDLE cycle. Re-asserting a req bit during WAIT:
  - sets that bit via the safe path, and
  - removes it from pending clears; no stale clear is ever applied.
- Safe set and sequenced clear on different bits in the same edge: both take effect.
- A bit never appears in set_mask and pend at the same time.
- busy = (state == WAIT) | (pend != 0). Combinational from registered state and the inputs.
- Register map, written when chipselect & ~write_n:
  - addr 0, RW: delay_reg = writedata[DLY_W-1:0]. Reads zero-extended. A write during WAIT does not alter the running counter; it is used at the next load.
  - addr 1, RO: bit0 = busy, bit1 = (state == WAIT); other bits 0.
  - addr 2, RO: oe_out, zero-extended to 32 bits.
  - addr 3, RO: reads 0.
  - Writes to addresses 1-3 are ignored.
- readdata is a combinational mux of address and does not depend on chipselect.

Test Plan:
- Reset release with oe_req = 0xFFFFFFFF:
  - oe_out = 0xFFFFFFFF, busy = 0, readdata at addr 0 = 1000.
- Write delay = 3, then oe_req = 0xFFFFFFF0:
  - oe_out bits clear in order 0, 1, 2, 3.
  - Clear edges exactly 5 cycles apart.
  - busy = 0 on the cycle after the final WAIT exits with pend = 0.
- Mid-sequence after bit 1 clears, oe_req = 0xFFFFFFFF:
  - oe_out = 0xFFFFFFFF one edge later.
  - bits 2 and 3 never clear.
  - FSM finishes WAIT, then IDLE with busy = 0.
- delay = 0, oe_req = 0x0000000F with oe_out = 0xFFFFFFFF:
  - 28 clears, bits 4..31 ascending, 2 cycles apart.
  - Final oe_out = 0x0000000F.
- Write delay = 10 during a WAIT with counter = 5:
  - current wait ends after the remaining 5 cycles plus the exit cycle.
  - the next spacing is 12 cycles.
- Assert reset_n low mid-WAIT with oe_out = 0xFFFFFF00:
  - oe_out = 0xFFFFFFFF, state = IDLE, delay = 1000 asynchronously.
  - After release with oe_req = 0xFFFFFFFF, busy stays 0.
